// File: rtl/vec_pe_pkg.sv
// Package for the vector multiply-accumulate processing element.
// Holds the operation encoding, the source element width codes, and two helpers:
//   dest_width - destination element width in bits for a (vsew, widening) pair
//   pe_illegal - flags op/width combinations the PE cannot produce a result for
package vec_pe_pkg;

  typedef enum logic [1:0] {
    PE_MUL   = 2'd0,
    PE_MULH  = 2'd1,
    PE_MACC  = 2'd2,
    PE_NMSAC = 2'd3
  } pe_op_e;

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;

  // Widening doubles or quadruples the source width; the sum is kept 3 bits wide
  // so that out-of-range combinations still yield a width larger than 32.
  function automatic int unsigned dest_width(input logic [1:0] vsew, input logic [1:0] widening);
    logic [2:0] sh;
    sh = {1'b0, vsew} + {1'b0, widening};
    return 32'd8 << sh;
  endfunction

  function automatic logic pe_illegal(input pe_op_e op, input logic [1:0] vsew,
                                      input logic [1:0] widening);
    logic bad;
    bad = 1'b0;
    if (vsew == 2'd3 || widening == 2'd3) bad = 1'b1;
    if (dest_width(vsew, widening) > 32) bad = 1'b1;
    // The high half only makes sense for a same-width product.
    if (op == PE_MULH && widening != 2'd0) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/vec_pe_pipe_reg.sv
// Single valid/ready pipeline register with synchronous flush.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   flush_i          clears the held entry at the next edge; incoming data is discarded
//   valid_i/ready_o  upstream handshake (ready_o = empty or downstream draining)
//   data_i           upstream payload
//   valid_o/ready_i  downstream handshake
//   data_o           held payload (reset to zero)
module vec_pe_pipe_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic valid_d, valid_q;
  T     data_d, data_q;

  // An empty stage accepts regardless of downstream, so bubbles collapse.
  assign ready_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (ready_o) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/vec_pe_mac.sv
// Two-stage pipelined multiply-accumulate processing element.
// Stage 1 registers the full 64-bit signed product plus c, op, destination width, tag and
// the illegal flag; stage 2 registers the width-masked element result.
// Ports:
//   clk, n_reset                 clock, asynchronous active-low reset
//   flush                        synchronous kill of both stages
//   in_valid/in_ready            operand handshake
//   a, b, c                      sign-extended operands
//   op, vsew, widening           operation, source width code, widening factor
//   elem_idx                     element tag, passed through
//   out_valid/out_ready          result handshake
//   result, out_elem_idx, out_err  element result (zero above DW), tag, illegal flag
module vec_pe_mac
  import vec_pe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 5
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [1:0]        op,
  input  logic [1:0]        vsew,
  input  logic [1:0]        widening,
  input  logic [ID_W-1:0]   elem_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [ID_W-1:0]   out_elem_idx,
  output logic              out_err
);

  typedef struct packed {
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   c;
    pe_op_e              op;
    logic [1:0]          dsew;
    logic [ID_W-1:0]     tag;
    logic                err;
  } s1_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [ID_W-1:0]   tag;
    logic              err;
  } s2_t;

  s1_t  s1_in, s1_q;
  s2_t  s2_in, s2_q;
  logic s1_valid, s2_ready;

  // ---------------------------------------------------------------- stage 1 inputs
  always_comb begin
    s1_in      = '0;
    // Truncating a 64-bit product of sign-extended operands gives the exact signed product.
    s1_in.prod = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
    s1_in.c    = c;
    s1_in.op   = pe_op_e'(op);
    s1_in.dsew = vsew + widening;
    s1_in.tag  = elem_idx;
    s1_in.err  = pe_illegal(pe_op_e'(op), vsew, widening);
  end

  vec_pe_pipe_reg #(
    .T (s1_t)
  ) u_s1 (
    .clk_i   (clk),
    .rst_ni  (n_reset),
    .flush_i (flush),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (s1_in),
    .valid_o (s1_valid),
    .ready_i (s2_ready),
    .data_o  (s1_q)
  );

  // ---------------------------------------------------------------- stage 2 arithmetic
  logic [DATA_W-1:0] full;

  always_comb begin
    full = '0;
    // Only the low DW bits survive for MUL/MACC/NMSAC, and those depend only on the
    // low 32 bits of each operand, so a 32-bit add/subtract is exact.
    unique case (s1_q.op)
      PE_MUL:   full = s1_q.prod[DATA_W-1:0];
      PE_MULH: begin
        case (s1_q.dsew)
          SEW_8:   full = {24'd0, s1_q.prod[15:8]};
          SEW_16:  full = {16'd0, s1_q.prod[31:16]};
          default: full = s1_q.prod[63:32];
        endcase
      end
      PE_MACC:  full = s1_q.prod[DATA_W-1:0] + s1_q.c;
      PE_NMSAC: full = s1_q.c - s1_q.prod[DATA_W-1:0];
    endcase

    s2_in     = '0;
    s2_in.tag = s1_q.tag;
    s2_in.err = s1_q.err;
    if (!s1_q.err) begin
      case (s1_q.dsew)
        SEW_8:   s2_in.result = {24'd0, full[7:0]};
        SEW_16:  s2_in.result = {16'd0, full[15:0]};
        SEW_32:  s2_in.result = full;
        default: s2_in.result = '0;
      endcase
    end
  end

  vec_pe_pipe_reg #(
    .T (s2_t)
  ) u_s2 (
    .clk_i   (clk),
    .rst_ni  (n_reset),
    .flush_i (flush),
    .valid_i (s1_valid),
    .ready_o (s2_ready),
    .data_i  (s2_in),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (s2_q)
  );

  assign result       = s2_q.result;
  assign out_elem_idx = s2_q.tag;
  assign out_err      = s2_q.err;

endmodule

// File: tb/tb_vec_pe_mac.sv
module tb_vec_pe_mac;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  idx;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0, c = '0;
  logic [1:0]  op = '0, vsew = '0, widening = '0;
  logic [4:0]  elem_idx = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  out_elem_idx;
  logic        out_err;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_done = 1'b0;

  vec_pe_mac #(
    .DATA_W (32),
    .ID_W   (5)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .c            (c),
    .op           (op),
    .vsew         (vsew),
    .widening     (widening),
    .elem_idx     (elem_idx),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .out_elem_idx (out_elem_idx),
    .out_err      (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers, then keep DW bits.
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] cv, input logic [1:0] opv,
                                 input logic [1:0] vs, input logic [1:0] wd,
                                 input logic [4:0] idx);
    exp_t   e;
    longint p, cc, r, mask;
    int     dw;
    e.idx = idx;
    e.err = 1'b0;
    e.result = '0;
    if (vs == 2'd3 || wd == 2'd3 || int'(vs) + int'(wd) > 2 || (opv == 2'd1 && wd != 2'd0)) begin
      e.err = 1'b1;
      return e;
    end
    dw = 8 << (int'(vs) + int'(wd));
    p  = longint'($signed(av)) * longint'($signed(bv));
    cc = longint'($signed(cv));
    case (opv)
      2'd0:    r = p;
      2'd1:    r = p >>> dw;
      2'd2:    r = p + cc;
      default: r = cc - p;
    endcase
    mask = (longint'(1) << dw) - 1;
    r = r & mask;
    e.result = r[31:0];
    return e;
  endfunction

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                      input logic [1:0] opv, input logic [1:0] vs, input logic [1:0] wd,
                      input logic [4:0] idx, input exp_t e);
    @(posedge clk);
    #1;
    a = av; b = bv; c = cv; op = opv; vsew = vs; widening = wd; elem_idx = idx;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv,
                        input logic [1:0] opv, input logic [1:0] vs, input logic [1:0] wd,
                        input logic [4:0] idx);
    send(av, bv, cv, opv, vs, wd, idx, model(av, bv, cv, opv, vs, wd, idx));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) begin
      @(posedge clk);
      #2;
    end
    check("drain_left", sb.size(), 0);
  endtask

  // Monitor: a result transfers at the next rising edge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (n_reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got idx %h, expected no output", out_elem_idx);
      end else begin
        e = sb.pop_front();
        check("result", result, e.result);
        check("elem_idx", {27'd0, out_elem_idx}, {27'd0, e.idx});
        check("err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rc;
    logic [1:0]  rop, rvs, rwd;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_result", result, 0);
    check("rst_idx", {27'd0, out_elem_idx}, 0);
    check("rst_err", {31'd0, out_err}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    n_reset = 1'b1;
    out_ready = 1'b1;

    // MUL 8b, plus latency with output free
    send(32'hFFFF_FFFD, 32'h5, 32'h0, 2'd0, 2'd0, 2'd0, 5'd1, exp_t'{32'h0000_00F1, 5'd1, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_edge1_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", {31'd0, out_valid}, 1);
    idle(2);

    send(32'hFFFF_FFFE, 32'h7FFF, 32'h10, 2'd2, 2'd1, 2'd1, 5'd2,
         exp_t'{32'hFFFF_0012, 5'd2, 1'b0});
    send(32'h4000_0000, 32'h8, 32'h0, 2'd1, 2'd2, 2'd0, 5'd3, exp_t'{32'h0000_0002, 5'd3, 1'b0});
    send(32'h3, 32'h4, 32'd100, 2'd3, 2'd0, 2'd0, 5'd4, exp_t'{32'h0000_0058, 5'd4, 1'b0});
    idle(4);

    // Illegal 16b quad-widening, followed by a legal op
    send(32'h1234, 32'h5678, 32'h9, 2'd0, 2'd1, 2'd2, 5'd5, exp_t'{32'h0, 5'd5, 1'b1});
    send(32'hFFFF_FF80, 32'h2, 32'h0, 2'd0, 2'd1, 2'd0, 5'd6, exp_t'{32'h0000_FF00, 5'd6, 1'b0});
    idle(4);
    drain();

    // Back-pressure: out_ready low for 3 edges mid-stream
    fork
      begin
        for (int i = 0; i < 4; i++)
          send_m(32'(i * 7 - 9), 32'(i + 3), 32'(i * 100), 2'd2, 2'd1, 2'd0, 5'(10 + i));
        idle(1);
      end
      begin
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, in_ready}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Randomized stream with random output stalls
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          ra = $urandom; rb = $urandom; rc = $urandom;
          rop = 2'($urandom_range(0, 3));
          rvs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          rwd = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          send_m(ra, rb, rc, rop, rvs, rwd, 5'(i));
          if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Flush with two ops in flight; the op presented with flush is dropped
    out_ready = 1'b0;
    send_m(32'h11, 32'h22, 32'h0, 2'd0, 2'd2, 2'd0, 5'd20);
    send_m(32'h33, 32'h44, 32'h0, 2'd0, 2'd2, 2'd0, 5'd21);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    elem_idx = 5'd22;
    @(negedge clk);
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 0);
    out_ready = 1'b1;
    idle(3);
    send_m(32'h5, 32'h6, 32'h7, 2'd2, 2'd0, 2'd0, 5'd23);
    idle(1);
    drain();

    // Asynchronous reset mid-stream
    send_m(32'h100, 32'h3, 32'h0, 2'd0, 2'd2, 2'd0, 5'd24);
    send_m(32'h200, 32'h3, 32'h0, 2'd0, 2'd2, 2'd0, 5'd25);
    @(posedge clk);
    #3;
    in_valid = 1'b0;
    n_reset = 1'b0;
    #1;
    check("rstmid_out_valid", {31'd0, out_valid}, 0);
    check("rstmid_result", result, 0);
    check("rstmid_idx", {27'd0, out_elem_idx}, 0);
    check("rstmid_err", {31'd0, out_err}, 0);
    sb.delete();
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    idle(3);
    send_m(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 2'd3, 2'd2, 2'd0, 5'd26);
    idle(1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
